everloop_rx: RTL and testbench

- Single-wire WS2812-style stream decoder: the receive end of the everloop LED serial line.
- Samples the LED data line, measures each high pulse to recover bits, and packs them MSB-first into bytes.
- Writes each byte into port A of everloop_ram, so a transmitted frame can be looped back and compared against the source image.
- Also used as the input stage for daisy-chained boards.

---
 rtl/everloop_rx.sv | 212 +++++++++++++++++++++
 tb/tb_everloop_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/everloop_rx.sv
// everloop_rx: receive end of the everloop WS2812-style LED line.
// Measures each high pulse on the synchronized line, turns it into a bit,
// packs bits MSB-first into bytes and writes them through RAM port A.
module everloop_rx #(
  parameter int adr_width    = 11,
  parameter int max_bytes    = 2048,
  parameter int bit_thresh   = 30,
  parameter int min_high     = 5,
  parameter int max_high     = 60,
  parameter int reset_cycles = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 everloop_d,
  output logic                 en_a,
  output logic                 we_a,
  output logic [adr_width-1:0] adr_a,
  output logic [7:0]           dat_a,
  output logic                 frame_done,
  output logic [adr_width:0]   byte_count,
  output logic                 err,
  output logic                 overflow
);

  localparam int CNT_MAX = (reset_cycles > max_high) ? reset_cycles : max_high;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam int ACNT_W  = adr_width + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  RESET_C = CNT_W'(reset_cycles);
  localparam logic [CNT_W-1:0]  MIN_H   = CNT_W'(min_high);
  localparam logic [CNT_W-1:0]  MAX_H   = CNT_W'(max_high);
  localparam logic [CNT_W-1:0]  THR     = CNT_W'(bit_thresh);
  localparam logic [ACNT_W-1:0] MAX_B   = ACNT_W'(max_bytes);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // Level-duration counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  state_t              state_q, state_d;
  logic                sync1_q, din_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [ACNT_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [adr_width-1:0] adr_a_q, adr_a_d;
  logic [7:0]          dat_a_q, dat_a_d;
  logic                fd_q, fd_d;
  logic [ACNT_W-1:0]   bc_q, bc_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic                abort;
  logic                bit_v;
  logic [7:0]          byte_v;

  // Two-flop synchronizer: everloop_d is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      sync1_q <= everloop_d;
      din_q   <= sync1_q;
    end
  end

  // Decoder state, counters and registered RAM / status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      adr_a_q  <= '0;
      dat_a_q  <= '0;
      fd_q     <= 1'b0;
      bc_q     <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      adr_a_q  <= adr_a_d;
      dat_a_q  <= dat_a_d;
      fd_q     <= fd_d;
      bc_q     <= bc_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: pulse measurement, bit/byte assembly, frame end and error handling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    adr_d    = adr_q;
    we_d     = 1'b0;
    adr_a_d  = adr_a_q;
    dat_a_d  = dat_a_q;
    fd_d     = 1'b0;
    bc_d     = bc_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    abort    = 1'b0;
    bit_v    = 1'b0;
    byte_v   = 8'h00;

    case (state_q)
      SYNC: begin
        // Only a full reset-length low proves we are between frames.
        if (din_q) begin
          cnt_d = '0;
        end else if (cnt_q == RESET_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      IDLE: begin
        if (din_q) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt_q > MAX_H) begin
          abort = 1'b1;
        end else if (din_q) begin
          cnt_d = sat_inc(cnt_q);
        end else if (cnt_q < MIN_H) begin
          abort = 1'b1;
        end else begin
          bit_v   = (cnt_q >= THR);
          byte_v  = {shift_q[6:0], bit_v};
          shift_d = byte_v;
          state_d = LOW;
          cnt_d   = CNT_ONE;
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = '0;
            // Past the frame limit the byte is dropped but decoding goes on.
            if (adr_q < MAX_B) begin
              we_d    = 1'b1;
              adr_a_d = adr_q[adr_width-1:0];
              dat_a_d = byte_v;
              adr_d   = adr_q + ACNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      LOW: begin
        if (din_q) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == RESET_C) begin
          state_d  = IDLE;
          cnt_d    = '0;
          fd_d     = 1'b1;
          bc_d     = adr_q;
          adr_d    = '0;
          bitcnt_d = '0;
          shift_d  = '0;
          if (bitcnt_q != 3'd0) err_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = SYNC;
    endcase

    // A bad pulse abandons the frame; resynchronize before decoding again.
    if (abort) begin
      err_d    = 1'b1;
      state_d  = SYNC;
      cnt_d    = '0;
      adr_d    = '0;
      bitcnt_d = '0;
      shift_d  = '0;
    end
  end

  assign en_a       = we_q;
  assign we_a       = we_q;
  assign adr_a      = adr_a_q;
  assign dat_a      = dat_a_q;
  assign frame_done = fd_q;
  assign byte_count = bc_q;
  assign err        = err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_everloop_rx.sv
`timescale 1ns/1ps
// Bench for everloop_rx: two instances (full-size and 4-byte frame limit)
// share one line; a pulse-level model predicts writes and frame status.
module tb_everloop_rx;
  localparam int AW   = 11;
  localparam int LONG = 2520;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic line = 1'b0;

  logic          en0, we0, fd0, err0, ovf0;
  logic [AW-1:0] adr0;
  logic [7:0]    dat0;
  logic [AW:0]   bc0;
  logic          en1, we1, fd1, err1, ovf1;
  logic [AW-1:0] adr1;
  logic [7:0]    dat1;
  logic [AW:0]   bc1;

  always #10 clk = ~clk;

  everloop_rx #(.adr_width(AW)) dut0 (
    .clk(clk), .rst(rst_n), .everloop_d(line),
    .en_a(en0), .we_a(we0), .adr_a(adr0), .dat_a(dat0),
    .frame_done(fd0), .byte_count(bc0), .err(err0), .overflow(ovf0)
  );

  everloop_rx #(.adr_width(AW), .max_bytes(4)) dut1 (
    .clk(clk), .rst(rst_n), .everloop_d(line),
    .en_a(en1), .we_a(we1), .adr_a(adr1), .dat_a(dat1),
    .frame_done(fd1), .byte_count(bc1), .err(err1), .overflow(ovf1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (pulse level) ----------------
  int exp0[$];
  int exp1[$];
  int fd_seen0 = 0, fd_seen1 = 0, fd_exp = 0;
  bit m_sync, m_inframe, m_err;
  int m_nbits, m_shift;
  int m_adr[2];
  bit m_ovf[2];
  int m_bc[2];
  int m_max[2] = '{2048, 4};

  task automatic model_reset();
    m_sync = 0; m_inframe = 0; m_err = 0; m_nbits = 0; m_shift = 0;
    for (int k = 0; k < 2; k++) begin
      m_adr[k] = 0; m_ovf[k] = 0; m_bc[k] = 0;
    end
    exp0.delete();
    exp1.delete();
  endtask

  task automatic model_pulse(input int hi);
    if (!m_sync) return;
    if (hi < 5 || hi > 60) begin
      m_err = 1; m_sync = 0; m_inframe = 0; m_nbits = 0; m_shift = 0;
      m_adr[0] = 0; m_adr[1] = 0;
      return;
    end
    m_inframe = 1;
    m_shift = ((m_shift << 1) | ((hi >= 30) ? 1 : 0)) & 255;
    m_nbits++;
    if (m_nbits == 8) begin
      m_nbits = 0;
      for (int k = 0; k < 2; k++) begin
        if (m_adr[k] < m_max[k]) begin
          if (k == 0) exp0.push_back(m_adr[k] * 256 + m_shift);
          else        exp1.push_back(m_adr[k] * 256 + m_shift);
          m_adr[k]++;
        end else begin
          m_ovf[k] = 1;
        end
      end
    end
  endtask

  task automatic model_low(input int lo);
    if (lo < 2000) return;
    if (!m_sync) begin
      m_sync = 1;
      return;
    end
    if (m_inframe) begin
      fd_exp++;
      for (int k = 0; k < 2; k++) begin
        m_bc[k] = m_adr[k];
        m_adr[k] = 0;
      end
      if (m_nbits != 0) m_err = 1;
      m_nbits = 0; m_shift = 0; m_inframe = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int hi, input int lo);
    model_pulse(hi);
    line = 1'b1;
    repeat (hi) @(negedge clk);
    line = 1'b0;
    repeat (lo) @(negedge clk);
    model_low(lo);
  endtask

  task automatic low(input int n);
    line = 1'b0;
    repeat (n) @(negedge clk);
    model_low(n);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) pulse(40, 22);
      else      pulse(20, 42);
    end
  endtask

  task automatic rand_bit(input bit v);
    int hi, lo;
    hi = v ? int'($urandom_range(60, 30)) : int'($urandom_range(29, 5));
    lo = int'($urandom_range(60, 5));
    pulse(hi, lo);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".en0"}, int'(en0), 0);   chk({tag, ".we0"}, int'(we0), 0);
    chk({tag, ".adr0"}, int'(adr0), 0); chk({tag, ".dat0"}, int'(dat0), 0);
    chk({tag, ".fd0"}, int'(fd0), 0);   chk({tag, ".bc0"}, int'(bc0), 0);
    chk({tag, ".err0"}, int'(err0), 0); chk({tag, ".ovf0"}, int'(ovf0), 0);
    chk({tag, ".en1"}, int'(en1), 0);   chk({tag, ".we1"}, int'(we1), 0);
    chk({tag, ".adr1"}, int'(adr1), 0); chk({tag, ".dat1"}, int'(dat1), 0);
    chk({tag, ".fd1"}, int'(fd1), 0);   chk({tag, ".bc1"}, int'(bc1), 0);
    chk({tag, ".err1"}, int'(err1), 0); chk({tag, ".ovf1"}, int'(ovf1), 0);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, ".pending0"}, exp0.size(), 0);
    chk({tag, ".pending1"}, exp1.size(), 0);
    chk({tag, ".frames0"}, fd_seen0, fd_exp);
    chk({tag, ".frames1"}, fd_seen1, fd_exp);
    chk({tag, ".bc0"}, int'(bc0), m_bc[0]);
    chk({tag, ".bc1"}, int'(bc1), m_bc[1]);
    chk({tag, ".err0"}, int'(err0), int'(m_err));
    chk({tag, ".err1"}, int'(err1), int'(m_err));
    chk({tag, ".ovf0"}, int'(ovf0), int'(m_ovf[0]));
    chk({tag, ".ovf1"}, int'(ovf1), int'(m_ovf[1]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    low(LONG);
  endtask

  // ---------------- output monitor ----------------
  int e0, e1;
  always @(negedge clk) begin
    if (we0) begin
      chk("wr0.en", int'(en0), 1);
      chk("wr0.expected", (exp0.size() > 0) ? 1 : 0, 1);
      if (exp0.size() > 0) begin
        e0 = exp0.pop_front();
        chk("wr0.adr", int'(adr0), e0 / 256);
        chk("wr0.dat", int'(dat0), e0 % 256);
      end
    end else if (en0) begin
      chk("en0.without_we", int'(we0), 1);
    end
    if (we1) begin
      chk("wr1.en", int'(en1), 1);
      chk("wr1.expected", (exp1.size() > 0) ? 1 : 0, 1);
      if (exp1.size() > 0) begin
        e1 = exp1.pop_front();
        chk("wr1.adr", int'(adr1), e1 / 256);
        chk("wr1.dat", int'(dat1), e1 % 256);
      end
    end else if (en1) begin
      chk("en1.without_we", int'(we1), 1);
    end
    if (fd0) fd_seen0++;
    if (fd1) fd_seen1++;
  end

  // ---------------- test sequence ----------------
  int thr_w[16] = '{29, 30, 29, 30, 30, 30, 29, 29, 5, 60, 5, 60, 30, 29, 60, 5};

  initial begin
    model_reset();
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // Basic three-byte frame.
    low(LONG);
    send_byte(8'hA5); send_byte(8'h0F); send_byte(8'hFF);
    low(LONG);
    checkpoint("basic");
    chk("basic.bc_const", int'(bc0), 3);

    // Threshold and legal width limits: 0x5C then 0x5A.
    foreach (thr_w[i]) pulse(thr_w[i], 30);
    low(LONG);
    checkpoint("thresh");
    chk("thresh.bc_const", int'(bc0), 2);

    // Partial trailing byte.
    do_reset();
    send_byte(8'h3C);
    for (int i = 0; i < 4; i++) pulse(40, 22);
    low(LONG);
    checkpoint("partial");
    chk("partial.err_const", int'(err0), 1);

    // Glitch pulse aborts; following pulses ignored until resync.
    do_reset();
    send_byte(8'h81);
    pulse(4, 40);
    send_byte(8'h77);
    low(LONG);
    checkpoint("glitch");
    send_byte(8'h42); send_byte(8'h24);
    low(LONG);
    checkpoint("after_glitch");

    // Frame limit on the 4-byte instance.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(255, 0)));
    low(LONG);
    checkpoint("ovf");
    chk("ovf.ovf1_const", int'(ovf1), 1);
    chk("ovf.bc1_const", int'(bc1), 4);
    send_byte(8'h99); send_byte(8'h66);
    low(LONG);
    checkpoint("after_ovf");

    // Overlong high.
    do_reset();
    pulse(61, LONG);
    checkpoint("longhigh");
    send_byte(8'hC3);
    low(LONG);
    checkpoint("after_longhigh");

    // Randomized frames, sometimes with a partial byte.
    for (int f = 0; f < 3; f++) begin
      int nb, nx;
      nb = int'($urandom_range(4, 1));
      nx = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
      for (int b = 0; b < nb * 8 + nx; b++) rand_bit(1'($urandom_range(1, 0)));
      low(LONG);
      checkpoint("random");
    end

    // Reset in the middle of the second byte.
    send_byte(8'hA5);
    pulse(40, 22); pulse(20, 42); pulse(40, 10);
    chk("midrst.pending0", exp0.size(), 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    model_reset();
    rst_n = 1'b1;
    low(100);
    send_byte(8'hEE); send_byte(8'h12);
    low(LONG);
    checkpoint("unsynced");
    send_byte(8'h5A);
    low(LONG);
    checkpoint("clean");
    chk("clean.bc_const", int'(bc0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
